// File: rtl/stepdown_loop_qualifier.sv
// Stepdown loop input qualifier: sync, debounce, post-enable blanking
// and minimum-on hold in front of the switch driver.
module stepdown_loop_qualifier #(
  parameter int N_IN       = 3,
  parameter int DEB_W      = 4,
  parameter int BLANK_CYC  = 8,
  parameter int MIN_ON_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tstate,
  input  logic [N_IN-1:0]  in,
  input  logic [DEB_W-1:0] deb_cyc,
  output logic             o,
  output logic             armed,
  input  logic             CELG,
  input  logic             CELV,
  input  logic             CELSUB
);

  localparam int MAXC = (BLANK_CYC > MIN_ON_CYC) ? BLANK_CYC : MIN_ON_CYC;
  localparam int CW_R = $clog2(MAXC + 1);
  localparam int CW   = (CW_R < 1) ? 1 : CW_R;

  localparam logic [CW-1:0] BLANK_LD =
    CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [CW-1:0] MINON_LD =
    CW'((MIN_ON_CYC > 1) ? MIN_ON_CYC - 1 : 0);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_BLANK = 2'd1,
    S_ARMED = 2'd2,
    S_ON    = 2'd3
  } state_t;

  // Power pins carry no logic; folded here so they are visibly consumed.
  logic unused_pwr;
  assign unused_pwr = ^{CELG, CELV, CELSUB};

  logic            ts_m;
  logic            ts_s;
  logic [N_IN-1:0] in_m;
  logic [N_IN-1:0] in_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_m <= 1'b0;
      ts_s <= 1'b0;
      in_m <= '0;
      in_s <= '0;
    end else begin
      ts_m <= tstate;
      ts_s <= ts_m;
      in_m <= in;
      in_s <= in_m;
    end
  end

  logic [N_IN-1:0]            q;
  logic [N_IN-1:0][DEB_W-1:0] cnt;
  logic [DEB_W:0]             thr;
  logic                       all_q;

  assign thr   = (deb_cyc == '0) ? (DEB_W+1)'(1) : {1'b0, deb_cyc};
  assign all_q = &q;

  // Compare cnt+1 so a lowered deb_cyc releases a long mismatch at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      cnt <= '0;
    end else begin
      for (int k = 0; k < N_IN; k++) begin
        if (in_s[k] == q[k]) begin
          cnt[k] <= '0;
        end else if (({1'b0, cnt[k]} + (DEB_W+1)'(1)) >= thr) begin
          q[k]   <= in_s[k];
          cnt[k] <= '0;
        end else if (cnt[k] != '1) begin
          cnt[k] <= cnt[k] + DEB_W'(1);
        end
      end
    end
  end

  state_t        state;
  logic [CW-1:0] ctr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_OFF;
      ctr   <= '0;
      o     <= 1'b0;
      armed <= 1'b0;
    end else if (!ts_s) begin
      state <= S_OFF;
      ctr   <= '0;
      o     <= 1'b0;
      armed <= 1'b0;
    end else begin
      unique case (state)
        S_OFF: begin
          if (BLANK_CYC == 0) begin
            state <= S_ARMED;
            armed <= 1'b1;
          end else begin
            state <= S_BLANK;
            ctr   <= BLANK_LD;
          end
        end
        S_BLANK: begin
          if (ctr == '0) begin
            state <= S_ARMED;
            armed <= 1'b1;
          end else begin
            ctr <= ctr - CW'(1);
          end
        end
        S_ARMED: begin
          if (all_q) begin
            state <= S_ON;
            o     <= 1'b1;
            ctr   <= MINON_LD;
          end
        end
        S_ON: begin
          if (ctr != '0) begin
            ctr <= ctr - CW'(1);
          end else if (!all_q) begin
            state <= S_ARMED;
            o     <= 1'b0;
          end
        end
        default: begin
          state <= S_OFF;
          o     <= 1'b0;
          armed <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stepdown_loop_qualifier.sv
// Bench for stepdown_loop_qualifier: timing of blanking, debounce,
// min-on hold, enable drop, async reset and runtime debounce change.
module tb_stepdown_loop_qualifier;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tstate = 1'b0;
  logic [2:0] in = 3'b000;
  logic [3:0] deb_cyc = 4'd3;
  logic       o;
  logic       armed;
  logic       celg = 1'b0;
  logic       celv = 1'b1;
  logic       celsub = 1'b0;

  int total = 0;
  int bad = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  stepdown_loop_qualifier #(
    .N_IN(3),
    .DEB_W(4),
    .BLANK_CYC(8),
    .MIN_ON_CYC(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tstate(tstate),
    .in(in),
    .deb_cyc(deb_cyc),
    .o(o),
    .armed(armed),
    .CELG(celg),
    .CELV(celv),
    .CELSUB(celsub)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_o(input logic v, input int lim, output int n);
    n = -1;
    for (int k = 1; k <= lim; k++) begin
      tick();
      if (o === v) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic rise_run(input string tag, input int lim);
    int arm_at;
    int o_at;
    int blank_hi;
    int e;
    arm_at = -1;
    o_at = -1;
    blank_hi = 0;
    for (int k = 1; k <= lim; k++) begin
      tick();
      if (armed === 1'b1 && arm_at < 0) arm_at = k;
      if (o === 1'b1 && o_at < 0) o_at = k;
      if (armed !== 1'b1 && o !== 1'b0) blank_hi++;
    end
    e = exp_q.pop_front();
    total++;
    if (arm_at !== e) begin
      bad++;
      $display("FAIL %s armed_rise got=%0d want=%0d", tag, arm_at, e);
    end
    e = exp_q.pop_front();
    total++;
    if (o_at !== e) begin
      bad++;
      $display("FAIL %s o_rise got=%0d want=%0d", tag, o_at, e);
    end
    e = exp_q.pop_front();
    total++;
    if (blank_hi !== e) begin
      bad++;
      $display("FAIL %s o_in_blank got=%0d want=%0d", tag, blank_hi, e);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    tstate = 1'b0;
    in = 3'b000;
    deb_cyc = 4'd3;
    repeat (3) tick();
    total++;
    if (o !== 1'b0) begin
      bad++;
      $display("FAIL reset_o got=%b want=0", o);
    end
    total++;
    if (armed !== 1'b0) begin
      bad++;
      $display("FAIL reset_armed got=%b want=0", armed);
    end
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_startup();
    exp_q.push_back(11);
    exp_q.push_back(12);
    exp_q.push_back(0);
    tstate = 1'b1;
    in = 3'b111;
    rise_run("startup", 20);
  endtask

  task automatic test_glitch();
    int lo;
    int fall;
    int e;
    exp_q.push_back(0);
    exp_q.push_back(6);
    in = 3'b101;
    tick();
    tick();
    in = 3'b111;
    lo = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (o !== 1'b1) lo++;
    end
    e = exp_q.pop_front();
    total++;
    if (lo !== e) begin
      bad++;
      $display("FAIL glitch2_low_cycles got=%0d want=%0d", lo, e);
    end
    in = 3'b101;
    fall = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 3) in = 3'b111;
      if (o === 1'b0 && fall < 0) fall = k;
    end
    e = exp_q.pop_front();
    total++;
    if (fall !== e) begin
      bad++;
      $display("FAIL glitch3_fall got=%0d want=%0d", fall, e);
    end
  endtask

  task automatic test_min_on();
    int n;
    int hi;
    int e;
    exp_q.push_back(6);
    exp_q.push_back(4);
    exp_q.push_back(4);
    in = 3'b000;
    wait_o(1'b0, 20, n);
    e = exp_q.pop_front();
    total++;
    if (n !== e) begin
      bad++;
      $display("FAIL minon_drop_all got=%0d want=%0d", n, e);
    end
    deb_cyc = 4'd0;
    repeat (4) tick();
    in = 3'b111;
    wait_o(1'b1, 20, n);
    e = exp_q.pop_front();
    total++;
    if (n !== e) begin
      bad++;
      $display("FAIL minon_rise_deb0 got=%0d want=%0d", n, e);
    end
    in = 3'b110;
    hi = 1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (o === 1'b1) hi++;
      else break;
    end
    e = exp_q.pop_front();
    total++;
    if (hi !== e) begin
      bad++;
      $display("FAIL minon_hold got=%0d want=%0d", hi, e);
    end
  endtask

  task automatic test_tstate_drop();
    int n;
    int e;
    exp_q.push_back(6);
    exp_q.push_back(3);
    deb_cyc = 4'd3;
    in = 3'b111;
    wait_o(1'b1, 20, n);
    e = exp_q.pop_front();
    total++;
    if (n !== e) begin
      bad++;
      $display("FAIL tdrop_pre_rise got=%0d want=%0d", n, e);
    end
    tstate = 1'b0;
    wait_o(1'b0, 10, n);
    e = exp_q.pop_front();
    total++;
    if (n !== e) begin
      bad++;
      $display("FAIL tdrop_fall got=%0d want=%0d", n, e);
    end
    total++;
    if (armed !== 1'b0) begin
      bad++;
      $display("FAIL tdrop_armed got=%b want=0", armed);
    end
    exp_q.push_back(11);
    exp_q.push_back(12);
    exp_q.push_back(0);
    tstate = 1'b1;
    rise_run("reblank", 15);
  endtask

  task automatic test_reset_mid_on();
    total++;
    if (o !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre_on got=%b want=1", o);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (o !== 1'b0) begin
      bad++;
      $display("FAIL rst_async_o got=%b want=0", o);
    end
    total++;
    if (armed !== 1'b0) begin
      bad++;
      $display("FAIL rst_async_armed got=%b want=0", armed);
    end
    repeat (2) tick();
    exp_q.push_back(11);
    exp_q.push_back(12);
    exp_q.push_back(0);
    rst_n = 1'b1;
    rise_run("rst_rerun", 20);
  endtask

  task automatic test_deb_change();
    int fall;
    int hi;
    int e;
    exp_q.push_back(6);
    exp_q.push_back(0);
    deb_cyc = 4'd7;
    tick();
    in = 3'b110;
    fall = -1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (o === 1'b0 && fall < 0) fall = k;
    end
    deb_cyc = 4'd2;
    for (int k = 5; k <= 20; k++) begin
      tick();
      if (o === 1'b0 && fall < 0) fall = k;
    end
    e = exp_q.pop_front();
    total++;
    if (fall !== e) begin
      bad++;
      $display("FAIL debchg_fall got=%0d want=%0d", fall, e);
    end
    hi = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (o !== 1'b0) hi++;
    end
    e = exp_q.pop_front();
    total++;
    if (hi !== e) begin
      bad++;
      $display("FAIL debchg_no_assert got=%0d want=%0d", hi, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_startup();
    test_glitch();
    test_min_on();
    test_tstate_drop();
    test_reset_mid_on();
    test_deb_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stepdown_loop_qualifier.md
# stepdown_loop_qualifier

Parametrised input qualifier for the stepdown loop control. It asserts `o` only when all `N_IN` loop-request inputs have been stable-high and the `tstate` enable is active. Compared with the plain gated-AND it adds:
- input synchronisation and per-channel debounce;
- a post-enable blanking window;
- a minimum-on hold.

It sits between the comparator/request logic and the stepdown switch driver.

## Interface
Parameters:
- `N_IN`, 3, number of qualified inputs (1..16)
- `DEB_W`, 4, width of the runtime debounce-count input
- `BLANK_CYC`, 8, cycles of forced-off blanking after `tstate` becomes active (0 = none)
- `MIN_ON_CYC`, 4, minimum cycles `o` stays high once asserted (0 or 1 = no hold beyond one cycle)

Ports:
- `clk`  in  1  block clock; all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `tstate`  in  1  loop enable, asynchronous to `clk`
- `in`  in  N_IN  loop-request inputs, asynchronous to `clk`
- `deb_cyc`  in  DEB_W  debounce length in cycles, quasi-static
- `o`  out  1  qualified output to switch driver, registered
- `armed`  out  1  high in ARMED or ON state, registered
- `CELG`, `CELV`, `CELSUB`  in  1  supply/ground/substrate pins; no logical function, routed to every leaf cell

## Operation
- `tstate` and each `in[k]` pass through a 2-flop synchroniser, giving `ts_s` and `in_s[k]`.
- Debounce per channel:
  - filtered value `q[k]` and counter `cnt[k]` (DEB_W bits).
  - If `in_s[k] == q[k]`: `cnt[k]` is cleared.
  - Else `cnt[k]` increments. When the mismatch has persisted `max(deb_cyc,1)` consecutive cycles, `q[k]` takes `in_s[k]` and `cnt[k]` clears.
  - `deb_cyc = 0` behaves as 1, so `q` is the registered `in_s`.
  - A mismatch shorter than `max(deb_cyc,1)` cycles never changes `q`.
  - `cnt` saturates and never wraps.
- `all_q = &q`. `tstate` is not debounced.
- FSM states, encoded, with registered outputs:
  - OFF: `o=0`, `armed=0`. If `ts_s=1`, go to BLANK, or straight to ARMED when `BLANK_CYC=0`. The blank counter loads `BLANK_CYC-1`.
  - BLANK: `o=0`, `armed=0`. Inputs are ignored. The counter decrements; at 0 the FSM goes to ARMED.
  - ARMED: `o=0`, `armed=1`. If `all_q=1`, go to ON and load the min-on counter with `MIN_ON_CYC-1`, saturating at 0.
  - ON: `o=1`, `armed=1`. The counter decrements to 0 and holds. If the counter is 0 and `all_q=0`, go to ARMED.
- Priority: `ts_s=0` in any state forces OFF on the next edge. This overrides blanking and the min-on hold.
- `ts_s` falling and rising again always restarts a full blanking window.
- Debounce runs in every state, including OFF and BLANK. `q` therefore reflects true input state on entry to ARMED.
- A `deb_cyc` change takes effect immediately. If `cnt[k]` is already at or above the new threshold while a mismatch exists, `q[k]` updates on the next edge.
- Counter widths are `$clog2(max(BLANK_CYC,MIN_ON_CYC)+1)`, with a minimum of 1.

## Timing
- Reset (`rst_n=0`, asynchronous): synchronisers, `q`, `cnt`, and counters are cleared; state is OFF; `o=0`, `armed=0`. Release is synchronous to the next `clk` edge. Reset asserted mid-ON drops `o` immediately (asynchronously).
- `tstate` rise to `armed` rise: 2 (sync) + 1 (OFF→BLANK) + `BLANK_CYC` cycles. With `BLANK_CYC=0` it is 3 cycles.
- Input edge to `q` change: 2 + `max(deb_cyc,1)` cycles.
- `q` change to `o` change: 1 cycle, subject to the FSM state and the min-on hold.
- `tstate` fall to `o` low: 3 cycles (2 sync + 1), regardless of the min-on hold.
- Simultaneous `ts_s=0` and `all_q` rising in ARMED: the FSM goes to OFF and `o` stays 0.

## Test plan
Bench parameters: `N_IN=3`, `BLANK_CYC=8`, `MIN_ON_CYC=4`, `deb_cyc=3`.

1. Reset, then `tstate=1` with `in=3'b111` held → `armed` rises at cycle 11 after the `tstate` edge; `o` rises 1 cycle later. `o=0` throughout the blanking window.
2. In ON, pulse `in[1]` low for 2 cycles → `o` stays 1. Pulse low for 3 cycles → `o` falls 6 cycles after the falling input edge.
3. In ON, drop `in[0]` 1 cycle after `o` rises, with `deb_cyc=0` → `o` is held high for exactly 4 cycles total, then falls.
4. In ON, drop `tstate` → `o` falls 3 cycles later, even inside the min-on window. Re-raise `tstate` → a full 8-cycle blank occurs again before `armed`.
5. Assert `rst_n=0` mid-ON → `o`, `armed` go 0 without a clock edge. Hold `in=3'b111` and `tstate=1` through release → the FSM re-runs OFF→BLANK→ARMED→ON with the case-1 timing.
6. Mid-mismatch with `cnt=2`, change `deb_cyc` from 7 to 2 → `q` updates on the next edge. With `in=3'b110` held, `o` never asserts.
